// File: rtl/abr_params_pkg.sv
// Shared ML-DSA parameters for the accelerator.
// Modulus and poly-memory address width.
package abr_params_pkg;
  localparam int unsigned ABR_MEM_ADDR_WIDTH = 15;
  localparam logic [22:0] MLDSA_Q = 23'd8380417;
endpackage

// File: rtl/sigdecode_z_defines_pkg.sv
// Types and constants for the signature-z decoder.
// Memory request bundles, gamma1 values, FSM states.
package sigdecode_z_defines_pkg;
  import abr_params_pkg::*;

  localparam int unsigned SIG_MEM_ADDR_W = 13;
  localparam logic [19:0] GAMMA1_17 = 20'h20000;
  localparam logic [19:0] GAMMA1_19 = 20'h80000;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10
  } rw_ops_e;

  typedef struct packed {
    rw_ops_e rd_wr_en;
    logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
  } mem_if_t;

  typedef struct packed {
    rw_ops_e rd_wr_en;
    logic [SIG_MEM_ADDR_W-1:0] addr;
  } sig_mem_if_t;

  typedef enum logic [1:0] {
    SDZ_IDLE,
    SDZ_RUN,
    SDZ_DRAIN,
    SDZ_DONE
  } sdz_state_e;
endpackage

// File: rtl/sigdecode_z_mode_unit.sv
// One-coefficient z decoder: z = gamma1 - x mapped into [0,q).
// Output is registered and forced to 0 when no valid input.
module sigdecode_z_mode_unit
  import abr_params_pkg::*;
  import sigdecode_z_defines_pkg::*;
#(
  parameter int REG_SIZE = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                zeroize,
  input  logic                en,
  input  logic                mode,
  input  logic [19:0]         x_i,
  output logic [REG_SIZE-1:0] coef_o
);

  logic [19:0] x;
  logic [19:0] g;
  logic signed [24:0] z;
  logic signed [24:0] zq;
  logic [REG_SIZE-1:0] coef_d;
  logic [REG_SIZE-1:0] coef_q;

  // Subtract from gamma1 and fold negatives up by q
  always_comb begin
    x = mode ? x_i : {2'b00, x_i[17:0]};
    g = mode ? GAMMA1_19 : GAMMA1_17;
    z = $signed({5'b0, g}) - $signed({5'b0, x});
    zq = z[24] ? z + $signed({2'b0, MLDSA_Q}) : z;
    coef_d = '0;
    if (en) coef_d = REG_SIZE'(zq);
  end

  // Coefficient register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) coef_q <= '0;
    else if (zeroize) coef_q <= '0;
    else coef_q <= coef_d;
  end

  assign coef_o = coef_q;

endmodule

// File: rtl/sigdecode_z_multi_top.sv
// Multi-lane signature-z decoder: sig memory -> poly memory.
// Optional norm flag: define SIGDECODE_Z_NORM_CHECK_EN.
module sigdecode_z_multi_top
  import abr_params_pkg::*;
  import sigdecode_z_defines_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ABR_MEM_ADDR_WIDTH,
  parameter int REG_SIZE       = 24,
  parameter int NUM_PORTS      = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        zeroize,
  input  logic                        sigdecode_z_enable,
  input  logic                        gamma1_mode,
  input  logic [2:0]                  num_poly,
  input  logic [SIG_MEM_ADDR_W-1:0]   src_base_addr,
  input  logic [MEM_ADDR_WIDTH-1:0]   dest_base_addr,
  input  logic [19:0]                 norm_bound,
  input  logic                        sigmem_stall,
  output sig_mem_if_t [NUM_PORTS-1:0] sigmem_rd_req,
  input  logic [NUM_PORTS-1:0][3:0][19:0] sigmem_rd_data,
  output mem_if_t [NUM_PORTS-1:0]     mem_wr_req,
  output logic [NUM_PORTS-1:0][3:0][REG_SIZE-1:0] mem_wr_data,
  output logic                        sigdecode_z_busy,
  output logic                        sigdecode_z_done,
  output logic                        z_norm_fail
);

  localparam int CW = 10;
  localparam logic [CW-1:0] STEP = CW'(NUM_PORTS);

  sdz_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] total_q, total_d;
  logic mode_q, mode_d;
  logic [SIG_MEM_ADDR_W-1:0] src_q, src_d;
  logic [MEM_ADDR_WIDTH-1:0] dest_q, dest_d;
  sig_mem_if_t [NUM_PORTS-1:0] rd_req_q, rd_req_d;
  mem_if_t [NUM_PORTS-1:0] wr_req_q, wr_req_d;
  logic v_data_q, v_data_d;
  logic pipe_busy;
  logic start;

  assign start = (state_q == SDZ_IDLE) && sigdecode_z_enable;
  assign pipe_busy = (rd_req_q[0].rd_wr_en == RW_READ) || v_data_q ||
                     (wr_req_q[0].rd_wr_en == RW_WRITE);

  // Sequencing, read issue and write-address generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    total_d  = total_q;
    mode_d   = mode_q;
    src_d    = src_q;
    dest_d   = dest_q;
    rd_req_d = '0;
    wr_req_d = '0;
    v_data_d = (rd_req_q[0].rd_wr_en == RW_READ);
    unique case (state_q)
      SDZ_IDLE: begin
        if (sigdecode_z_enable) begin
          mode_d  = gamma1_mode;
          total_d = CW'({num_poly, 6'd0});
          src_d   = src_base_addr;
          dest_d  = dest_base_addr;
          cnt_d   = '0;
          wcnt_d  = '0;
          state_d = (num_poly == 3'd0) ? SDZ_DONE : SDZ_RUN;
        end
      end
      SDZ_RUN: begin
        if (!sigmem_stall) begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            rd_req_d[p].rd_wr_en = RW_READ;
            rd_req_d[p].addr = src_q + SIG_MEM_ADDR_W'(cnt_q) +
                               SIG_MEM_ADDR_W'(p);
          end
          cnt_d = cnt_q + STEP;
          if (cnt_d == total_q) state_d = SDZ_DRAIN;
        end
      end
      SDZ_DRAIN: if (!pipe_busy) state_d = SDZ_DONE;
      SDZ_DONE:  state_d = SDZ_IDLE;
      default:   state_d = SDZ_IDLE;
    endcase
    if (v_data_q) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_req_d[p].rd_wr_en = RW_WRITE;
        wr_req_d[p].addr = ABR_MEM_ADDR_WIDTH'(dest_q +
          MEM_ADDR_WIDTH'(wcnt_q) + MEM_ADDR_WIDTH'(p));
      end
      wcnt_d = wcnt_q + STEP;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SDZ_IDLE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      total_q  <= '0;
      mode_q   <= 1'b0;
      src_q    <= '0;
      dest_q   <= '0;
      rd_req_q <= '0;
      wr_req_q <= '0;
      v_data_q <= 1'b0;
    end else if (zeroize) begin
      state_q  <= SDZ_IDLE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      total_q  <= '0;
      mode_q   <= 1'b0;
      src_q    <= '0;
      dest_q   <= '0;
      rd_req_q <= '0;
      wr_req_q <= '0;
      v_data_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      total_q  <= total_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      dest_q   <= dest_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      v_data_q <= v_data_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    for (genvar k = 0; k < 4; k++) begin : g_coef
      sigdecode_z_mode_unit #(.REG_SIZE(REG_SIZE)) u_unit (
        .clk     (clk),
        .reset_n (reset_n),
        .zeroize (zeroize),
        .en      (v_data_q),
        .mode    (mode_q),
        .x_i     (sigmem_rd_data[p][k]),
        .coef_o  (mem_wr_data[p][k])
      );
    end
  end

  assign sigmem_rd_req    = rd_req_q;
  assign mem_wr_req       = wr_req_q;
  assign sigdecode_z_busy = (state_q != SDZ_IDLE);
  assign sigdecode_z_done = (state_q == SDZ_DONE);

`ifdef SIGDECODE_Z_NORM_CHECK_EN
  logic [19:0] bound_q;
  logic fail_q, fail_d;
  logic [22:0] g23;
  logic [22:0] c23;
  logic [22:0] mag;

  // |z| recovered from the folded coefficient; sticky until next start
  always_comb begin
    fail_d = fail_q;
    g23 = mode_q ? {3'b0, GAMMA1_19} : {3'b0, GAMMA1_17};
    c23 = '0;
    mag = '0;
    if (wr_req_q[0].rd_wr_en == RW_WRITE) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int k = 0; k < 4; k++) begin
          c23 = mem_wr_data[p][k][22:0];
          mag = (c23 <= g23) ? c23 : MLDSA_Q - c23;
          if (mag >= {3'b0, bound_q}) fail_d = 1'b1;
        end
      end
    end
    if (start) fail_d = 1'b0;
  end

  // Norm flag and latched bound
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_q  <= 1'b0;
      bound_q <= '0;
    end else if (zeroize) begin
      fail_q  <= 1'b0;
      bound_q <= '0;
    end else begin
      fail_q  <= fail_d;
      if (start) bound_q <= norm_bound;
    end
  end

  assign z_norm_fail = fail_q;
`else
  logic unused_bound;
  assign unused_bound = ^norm_bound;
  assign z_norm_fail  = 1'b0;
`endif

endmodule
